// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter
// Description : Round-robin arbiter that shares one right shifter (logical or
//               arithmetic) between two valid/ready requesters. Each granted
//               result lands in a single registered output slot, tagged with
//               the ID of the requester that won.
//               Optional macro SHIFT_ARB_STATS_EN adds two 16-bit saturating
//               per-requester grant counters (grant_cnt0 / grant_cnt1).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_arbiter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [SHW-1:0]   req0_shift,
  input  logic             req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [SHW-1:0]   req1_shift,
  input  logic             req1_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  // Output slot and round-robin pointer
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_id_q,    out_id_d;
  logic             prio_q,      prio_d;

  // Arbitration and datapath intermediates
  logic                    w_slot_free;
  logic                    w_gnt0;
  logic                    w_gnt1;
  logic                    w_grant;
  logic                    w_win_id;
  logic [WIDTH-1:0]        w_win_data;
  logic [SHW-1:0]          w_win_shift;
  logic                    w_win_mode;
  logic signed [WIDTH-1:0] w_sdata;
  logic signed [WIDTH-1:0] w_ashr;
  logic [WIDTH-1:0]        w_lshr;
  logic [WIDTH-1:0]        w_shift_res;

  // Arbitration: the slot must be free, a lone valid wins, a contest goes to prio.
  // Readys are forced low while reset is held so no grant is advertised then.
  always_comb begin
    w_slot_free = ~out_valid_q | out_ready;
    w_gnt0      = rst_n & w_slot_free & req0_valid & (~req1_valid | ~prio_q);
    w_gnt1      = rst_n & w_slot_free & req1_valid & (~req0_valid |  prio_q);
    w_grant     = w_gnt0 | w_gnt1;
    w_win_id    = w_gnt1;
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  // Shift datapath on the winner's operand. The two shifts are kept in
  // separate statements so the arithmetic one stays in a signed context;
  // >>> on a signed value sign-fills even when the amount reaches WIDTH,
  // and >> zero-fills, which covers the oversized-shift cases directly.
  always_comb begin
    w_win_data  = w_win_id ? req1_data  : req0_data;
    w_win_shift = w_win_id ? req1_shift : req0_shift;
    w_win_mode  = w_win_id ? req1_mode  : req0_mode;
    w_sdata     = w_win_data;
    w_ashr      = w_sdata >>> w_win_shift;
    w_lshr      = w_win_data >> w_win_shift;
    w_shift_res = w_win_mode ? w_ashr : w_lshr;
  end

  // Next-state for the output slot and the priority pointer
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    prio_d      = prio_q;
    if (w_grant) begin
      out_valid_d = 1'b1;
      out_data_d  = w_shift_res;
      out_id_d    = w_win_id;
      prio_d      = ~w_win_id;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output slot and priority registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= 1'b0;
      prio_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      prio_q      <= prio_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  // Saturating grant counters, one per requester
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (w_gnt0 && (cnt0_q != 16'hFFFF)) begin
      cnt0_d = cnt0_q + 16'd1;
    end
    if (w_gnt1 && (cnt1_q != 16'hFFFF)) begin
      cnt1_d = cnt1_q + 16'd1;
    end
  end

  // Grant counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_arbiter
// Description : Self-checking bench for shift_arbiter: table of single-request
//               shift vectors plus hand-written sequences for reset, contention,
//               back-pressure, mid-stream reset and (with SHIFT_ARB_STATS_EN)
//               the grant counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_mode;
  logic [7:0] req0_data;
  logic [2:0] req0_shift;
  logic       req1_valid, req1_ready, req1_mode;
  logic [7:0] req1_data;
  logic [2:0] req1_shift;
  logic       out_valid, out_ready, out_id;
  logic [7:0] out_data;
`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  shift_arbiter #(.WIDTH(8), .SHW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_shift (req0_shift),
    .req0_mode  (req0_mode),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_shift (req1_shift),
    .req1_mode  (req1_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic [2:0] sh;
    logic       mode;
    logic [7:0] exp;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       exp_w;
    logic [7:0] exp_d;

    // data 8'b10101010 sweep, then a few extra operands on either requester
    vecs[0]  = '{1'b0, 8'hAA, 3'd0, 1'b0, 8'hAA};
    vecs[1]  = '{1'b0, 8'hAA, 3'd1, 1'b0, 8'h55};
    vecs[2]  = '{1'b0, 8'hAA, 3'd2, 1'b0, 8'h2A};
    vecs[3]  = '{1'b0, 8'hAA, 3'd3, 1'b0, 8'h15};
    vecs[4]  = '{1'b0, 8'hAA, 3'd4, 1'b0, 8'h0A};
    vecs[5]  = '{1'b0, 8'hAA, 3'd5, 1'b0, 8'h05};
    vecs[6]  = '{1'b0, 8'hAA, 3'd6, 1'b0, 8'h02};
    vecs[7]  = '{1'b0, 8'hAA, 3'd7, 1'b0, 8'h01};
    vecs[8]  = '{1'b0, 8'hAA, 3'd0, 1'b1, 8'hAA};
    vecs[9]  = '{1'b0, 8'hAA, 3'd1, 1'b1, 8'hD5};
    vecs[10] = '{1'b0, 8'hAA, 3'd2, 1'b1, 8'hEA};
    vecs[11] = '{1'b0, 8'hAA, 3'd3, 1'b1, 8'hF5};
    vecs[12] = '{1'b0, 8'hAA, 3'd4, 1'b1, 8'hFA};
    vecs[13] = '{1'b0, 8'hAA, 3'd5, 1'b1, 8'hFD};
    vecs[14] = '{1'b0, 8'hAA, 3'd6, 1'b1, 8'hFE};
    vecs[15] = '{1'b0, 8'hAA, 3'd7, 1'b1, 8'hFF};
    vecs[16] = '{1'b0, 8'h7F, 3'd7, 1'b1, 8'h00};
    vecs[17] = '{1'b1, 8'h96, 3'd2, 1'b1, 8'hE5};
    vecs[18] = '{1'b1, 8'h80, 3'd7, 1'b0, 8'h01};

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_data = 8'h00; req0_shift = 3'd0; req0_mode = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_shift = 3'd0; req1_mode = 1'b0;
    out_ready = 1'b1;

    // ---------------- reset then idle ----------------
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_id, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
`ifdef SHIFT_ARB_STATS_EN
    check("rst_cnt0", grant_cnt0, 0);
    check("rst_cnt1", grant_cnt1, 0);
`endif
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst_held_ready0", req0_ready, 0);
    check("rst_held_ready1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      after_edge();
      check("idle_out_valid", out_valid, 0);
      check("idle_out_data", out_data, 0);
      check("idle_ready", {req0_ready, req1_ready}, 0);
    end

    // ---------------- table-driven single-requester vectors ----------------
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      req0_valid = ~vecs[i].id;
      req1_valid =  vecs[i].id;
      req0_data  = vecs[i].data; req0_shift = vecs[i].sh; req0_mode = vecs[i].mode;
      req1_data  = vecs[i].data; req1_shift = vecs[i].sh; req1_mode = vecs[i].mode;
      #1;
      check($sformatf("vec%0d_ready", i), {req1_ready, req0_ready}, vecs[i].id ? 2'b10 : 2'b01);
      after_edge();
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      check($sformatf("vec%0d_id", i), out_id, vecs[i].id);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    after_edge();
    check("drain_valid", out_valid, 0);
    check("drain_data_kept", out_data, 8'h01);
    check("drain_id_kept", out_id, 1);

    // ---------------- contention after a fresh reset ----------------
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h80; req0_shift = 3'd1; req0_mode = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h80; req1_shift = 3'd1; req1_mode = 1'b0;
    exp_w = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("cont_ready", {req1_ready, req0_ready}, exp_w ? 2'b10 : 2'b01);
      after_edge();
      exp_d = exp_w ? 8'h40 : 8'hC0;
      check("cont_data", out_data, exp_d);
      check("cont_id", out_id, exp_w);
      check("cont_valid", out_valid, 1);
      exp_w = ~exp_w;
      @(negedge clk);
    end

    // ---------------- back-pressure: slot full for 3 cycles ----------------
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", {req1_ready, req0_ready}, 0);
      after_edge();
      check("bp_valid", out_valid, 1);
      check("bp_data_hold", out_data, 8'h40);
      check("bp_id_hold", out_id, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready0", req0_ready, 1);
    after_edge();
    check("bp_release_data", out_data, 8'hC0);
    check("bp_release_id", out_id, 0);
    check("bp_release_valid", out_valid, 1);

    // ---------------- asynchronous reset mid-stream (prio is 1 here) ----------------
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_ready", {req1_ready, req0_ready}, 0);
    after_edge();
    check("mid_rst_hold_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {req1_ready, req0_ready}, 2'b01);
    after_edge();
    check("post_rst_id", out_id, 0);
    check("post_rst_data", out_data, 8'hC0);

`ifdef SHIFT_ARB_STATS_EN
    // ---------------- grant counters ----------------
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req1_valid = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    req1_valid = 1'b0;
    #1;
    check("stats_cnt0", grant_cnt0, 10);
    check("stats_cnt1", grant_cnt1, 4);
    req0_valid = 1'b1;
    for (int i = 0; i < 65537; i++) @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check("stats_sat_cnt0", grant_cnt0, 16'hFFFF);
    check("stats_sat_cnt1", grant_cnt1, 4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
